keypad_scan_debounce: RTL and testbench

//   Parametrised matrix-keypad scanner. Drives one row low at a time, samples synchronised

---
 rtl/keypad_scan_debounce.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// Purpose: matrix-keypad scanner with press/release debounce and a two-digit shift display.
// Latency: key_valid rises DEBOUNCE_CYCLES+1 clk after the CHECK sample that first sees a single key.
// Backpressure: none; key_valid is a one-cycle pulse. Optional auto-repeat is built with `define KEY_REPEAT_EN.
module keypad_scan_debounce #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_CYCLES   = 500000,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int IW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_sync,
  output logic [ROWS-1:0] r_sel,
  output logic            key_valid,
  output logic [IW-1:0]   key_index,
  output logic [3:0]      key_code,
  output logic            key_held,
  output logic [3:0]      right,
  output logic [3:0]      left
);

  // The repeat period only sizes the counter when auto-repeat is built in.
`ifdef KEY_REPEAT_EN
  localparam int REP_TOP = REPEAT_CYCLES;
`else
  localparam int REP_TOP = 0 * REPEAT_CYCLES;
`endif
  localparam int TMAX0 = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int TMAX  = (TMAX0 > REP_TOP) ? TMAX0 : REP_TOP;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {SCAN, CHECK, DEBOUNCE, COMMIT, HOLD} state_t;

  state_t          state;
  logic [RW-1:0]   row;
  logic [COLS-1:0] col_hot;
  logic [CW-1:0]   col_idx;
  logic [TW-1:0]   cnt;
  logic            col_any;
  logic            col_one;
  logic [CW-1:0]   col_enc;
  logic [RW-1:0]   row_next;
  logic            rep_fire;
  logic            commit_now;
  int              idx_int;
  logic [3:0]      code_n;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == '1) ? v : v + TW'(1);
  endfunction

  // Standard 4x4 legend; any other geometry shows the low index bits.
  function automatic logic [3:0] code_of(input int idx);
    logic [3:0] c;
    c = 4'(idx);
    if (ROWS == 4 && COLS == 4) begin
      case (idx)
        0: c = 4'h1;  1: c = 4'h2;  2: c = 4'h3;  3: c = 4'hA;
        4: c = 4'h4;  5: c = 4'h5;  6: c = 4'h6;  7: c = 4'hB;
        8: c = 4'h7;  9: c = 4'h8; 10: c = 4'h9; 11: c = 4'hC;
        12: c = 4'hF; 13: c = 4'h0; 14: c = 4'hE; 15: c = 4'hD;
        default: c = 4'(idx);
      endcase
    end
    return c;
  endfunction

  assign r_sel      = ~(ROWS'(1) << row);
  assign col_any    = |col_sync;
  assign col_one    = col_any && ((col_sync & (col_sync - COLS'(1))) == '0);
  assign row_next   = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
  assign idx_int    = int'(row) * COLS + int'(col_idx);
  assign code_n     = code_of(idx_int);
  assign commit_now = (state == COMMIT) || rep_fire;

  // Column number of the single active column (meaningful only when col_one).
  always_comb begin
    col_enc = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_sync[c]) col_enc = CW'(c);
    end
  end

`ifdef KEY_REPEAT_EN
  logic [TW-1:0] rep_cnt;
  // Fire a repeat after REPEAT_CYCLES consecutive nonzero samples in HOLD.
  assign rep_fire = (state == HOLD) && col_any && (rep_cnt == TW'(REP_TOP - 1));

  // Repeat counter: cleared on commit and on any zero sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_cnt <= '0;
    else if (state != HOLD || !col_any || rep_fire) rep_cnt <= '0;
    else rep_cnt <= sat_inc(rep_cnt);
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Scan/debounce state machine: row pointer, timing counter, latched column, held flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SCAN;
      row      <= '0;
      cnt      <= '0;
      col_hot  <= '0;
      col_idx  <= '0;
      key_held <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (cnt >= TW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        CHECK: begin
          cnt <= '0;
          if (col_one) begin
            col_hot <= col_sync;
            col_idx <= col_enc;
            state   <= DEBOUNCE;
          end else begin
            // No key or several keys in this row: move on.
            row   <= row_next;
            state <= SCAN;
          end
        end
        DEBOUNCE: begin
          if (col_sync != col_hot) begin
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt >= TW'(DEBOUNCE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= COMMIT;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        COMMIT: begin
          cnt      <= '0;
          key_held <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          // Row stays frozen; only an all-clear run of DEBOUNCE_CYCLES releases.
          if (col_any) begin
            cnt <= '0;
          end else if (cnt >= TW'(DEBOUNCE_CYCLES - 1)) begin
            cnt      <= '0;
            key_held <= 1'b0;
            row      <= row_next;
            state    <= SCAN;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

  // Key outputs and digit shift register, updated on commit or repeat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_index <= '0;
      key_code  <= '0;
      left      <= '0;
      right     <= '0;
    end else begin
      key_valid <= commit_now;
      if (commit_now) begin
        left      <= right;
        right     <= code_n;
        key_index <= IW'(idx_int);
        key_code  <= code_n;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      col_sync;
  logic [3:0]      r_sel;
  logic            key_valid;
  logic [3:0]      key_index;
  logic [3:0]      key_code;
  logic            key_held;
  logic [3:0]      right;
  logic [3:0]      left;
  logic [3:0][3:0] keys;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;
  int held_lost;

  keypad_scan_debounce #(
    .ROWS(4), .COLS(4), .SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .col_sync(col_sync), .r_sel(r_sel),
    .key_valid(key_valid), .key_index(key_index), .key_code(key_code),
    .key_held(key_held), .right(right), .left(left)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column when its row is driven low.
  always_comb begin
    col_sync = '0;
    for (int r = 0; r < 4; r++) begin
      if (!r_sel[r]) col_sync = col_sync | keys[r];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic ticks_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, 32'(key_valid), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    keys  = '0;
    keys[1] = 4'b0100;
    tick();
    tick();
    chk("rst_rsel",  32'(r_sel),     32'hE);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held",  32'(key_held),  32'd0);
    chk("rst_index", 32'(key_index), 32'd0);
    chk("rst_code",  32'(key_code),  32'd0);
    chk("rst_digits", {24'd0, left, right}, 32'd0);
    reset = 1'b0;

    // Clean press row1/col2: row0 scanned empty, row1 checked at edge 6.
    ticks_quiet(10, "press_quiet");
    tick();
    chk("press_valid", 32'(key_valid), 32'd1);
    chk("press_code",  32'(key_code),  32'h6);
    chk("press_index", 32'(key_index), 32'd6);
    chk("press_right", 32'(right),     32'h6);
    chk("press_left",  32'(left),      32'h0);
    chk("press_held",  32'(key_held),  32'd1);
    chk("press_rsel",  32'(r_sel),     32'hD);
    keys = '0;
    tick();
    chk("press_pulse", 32'(key_valid), 32'd0);
    tick();
    tick();
    chk("rel_held_hi", 32'(key_held),  32'd1);
    tick();
    chk("rel_held_lo", 32'(key_held),  32'd0);
    chk("rel_rsel",    32'(r_sel),     32'hB);

    // Async reset while debouncing row2/col1.
    keys[2] = 4'b0010;
    ticks_quiet(4, "pre_rst_quiet");
    reset = 1'b1;
    #1;
    chk("arst_rsel",  32'(r_sel),     32'hE);
    chk("arst_right", 32'(right),     32'h0);
    chk("arst_left",  32'(left),      32'h0);
    chk("arst_valid", 32'(key_valid), 32'd0);
    keys = '0;
    keys[0] = 4'b0001;
    tick();
    reset = 1'b0;

    // Bounce on row0/col0: 1 at check, 0 next cycle, then 1 stable.
    ticks_quiet(3, "bounce_a");
    keys[0] = 4'b0000;
    ticks_quiet(1, "bounce_b");
    keys[0] = 4'b0001;
    ticks_quiet(7, "bounce_c");
    tick();
    chk("bounce_valid", 32'(key_valid), 32'd1);
    chk("bounce_code",  32'(key_code),  32'h1);
    chk("bounce_index", 32'(key_index), 32'd0);
    chk("bounce_right", 32'(right),     32'h1);
    keys = '0;
    ticks_quiet(3, "bounce_rel");
    chk("bounce_held_hi", 32'(key_held), 32'd1);
    tick();
    chk("bounce_held_lo", 32'(key_held), 32'd0);
    chk("bounce_rsel",    32'(r_sel),    32'hD);

    // Two columns in row1 at check: ignored, pointer moves to row2.
    keys[1] = 4'b0011;
    tick();
    tick();
    chk("multi_rsel_a", 32'(r_sel), 32'hD);
    tick();
    chk("multi_rsel_b", 32'(r_sel), 32'hB);
    chk("multi_valid",  32'(key_valid), 32'd0);
    chk("multi_held",   32'(key_held),  32'd0);
    keys = '0;

    // Long hold on row3/col3.
    keys[3] = 4'b1000;
    ticks_quiet(10, "hold_quiet");
    tick();
    chk("hold_valid", 32'(key_valid), 32'd1);
    chk("hold_code",  32'(key_code),  32'hD);
    chk("hold_index", 32'(key_index), 32'd15);
    chk("hold_right", 32'(right),     32'hD);
    chk("hold_left",  32'(left),      32'h1);
    chk("hold_rsel",  32'(r_sel),     32'h7);
    pulses    = 0;
    held_lost = 0;
    for (int i = 0; i < 89; i++) begin
      tick();
      if (key_valid) pulses++;
      if (!key_held) held_lost++;
    end
    chk("hold_held_all", 32'(held_lost), 32'd0);
`ifdef KEY_REPEAT_EN
    chk("hold_pulses", 32'(pulses), 32'd5);
    chk("hold_left_rep", 32'(left), 32'hD);
`else
    chk("hold_pulses", 32'(pulses), 32'd0);
    chk("hold_left_one", 32'(left), 32'h1);
`endif
    chk("hold_right_end", 32'(right), 32'hD);
    keys = '0;
    ticks_quiet(3, "hold_rel");
    chk("hold_rel_held_hi", 32'(key_held), 32'd1);
    tick();
    chk("hold_rel_held_lo", 32'(key_held), 32'd0);
    chk("hold_wrap_rsel",   32'(r_sel),    32'hE);
    ticks_quiet(3, "resume_quiet");
    chk("resume_rsel", 32'(r_sel), 32'hD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
